// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller FSM states and the hard-wired zero register number.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;   // operand from register file
    localparam logic [1:0] FWD_WB  = 2'd1;   // operand from WB stage data
    localparam logic [1:0] FWD_MEM = 2'd2;   // operand from MEM stage data

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_e;

    // True when a producer register number matches a consumer number and is
    // not the zero register (r0 is never a real dependency).
    function automatic logic reg_match(input logic [4:0] prod, input logic [4:0] cons);
        return (prod != REG_ZERO) && (prod == cons);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller. The core
// (master) drives stage register numbers and enables; the controller (slave)
// returns forwarding selects and stall/flush controls.
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_rd_hilo;
    logic [4:0] ex_rw;
    logic       ex_we;
    logic       ex_memread;
    logic       ex_br_taken;
    logic       ex_mdu_start;
    logic [4:0] mem_rw;
    logic       mem_we;
    logic [4:0] wb_rw;
    logic       wb_we;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_pc;
    logic       stall_ifid;
    logic       flush_ifid;
    logic       flush_idex;
    logic       mdu_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_rd_hilo,
        output ex_rw, ex_we, ex_memread, ex_br_taken, ex_mdu_start,
        output mem_rw, mem_we, wb_rw, wb_we,
        input  fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, flush_idex, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_rd_hilo,
        input  ex_rw, ex_we, ex_memread, ex_br_taken, ex_mdu_start,
        input  mem_rw, mem_we, wb_rw, wb_we,
        output fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, flush_idex, mdu_busy
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source operand. The MEM stage holds the
// younger result, so it wins over WB when both write the same register.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       use_i,
    input  logic [4:0] mem_rw_i,
    input  logic       mem_we_i,
    input  logic [4:0] wb_rw_i,
    input  logic       wb_we_i,
    output logic [1:0] sel_o
);

    // Priority compare: MEM, then WB, otherwise register file.
    always_comb begin
        sel_o = FWD_REG;
        if (use_i && mem_we_i && reg_match(mem_rw_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (use_i && wb_we_i && reg_match(wb_rw_i, src_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage core. Forwarding is
// purely combinational; a small FSM inserts load-use bubbles, flushes on taken
// branches and holds the front end while a HI/LO read waits on the MDU.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_if.slave    bus
);

    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MDU_LAT);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use_s;
    logic             hilo_wait_s;
    logic             mdu_busy_s;
    logic             stall_s;
    logic             flush_ifid_s;
    logic             flush_idex_s;

    hazard_ctrl_fwd_sel u_fwd_a (
        .src_i    (bus.id_rs),
        .use_i    (bus.id_use_rs),
        .mem_rw_i (bus.mem_rw),
        .mem_we_i (bus.mem_we),
        .wb_rw_i  (bus.wb_rw),
        .wb_we_i  (bus.wb_we),
        .sel_o    (bus.fwd_a)
    );

    hazard_ctrl_fwd_sel u_fwd_b (
        .src_i    (bus.id_rt),
        .use_i    (bus.id_use_rt),
        .mem_rw_i (bus.mem_rw),
        .mem_we_i (bus.mem_we),
        .wb_rw_i  (bus.wb_rw),
        .wb_we_i  (bus.wb_we),
        .sel_o    (bus.fwd_b)
    );

    assign mdu_busy_s  = (cnt_q != ZERO_C);
    assign load_use_s  = bus.ex_memread & bus.ex_we &
                         ((bus.id_use_rs & reg_match(bus.ex_rw, bus.id_rs)) |
                          (bus.id_use_rt & reg_match(bus.ex_rw, bus.id_rt)));
    assign hilo_wait_s = bus.id_rd_hilo & (mdu_busy_s | bus.ex_mdu_start);

    // MDU countdown: a start (re)loads the latency, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.ex_mdu_start) begin
            cnt_d = LAT_C;
        end else if (cnt_q != ZERO_C) begin
            cnt_d = cnt_q - ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Controller FSM next state and stall/flush controls.
    always_comb begin
        state_d      = state_q;
        stall_s      = 1'b0;
        flush_ifid_s = 1'b0;
        flush_idex_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.ex_br_taken) begin
                    // Wrong-path IF and ID instructions die; no bubble needed.
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                    state_d      = ST_RUN;
                end else if (load_use_s) begin
                    stall_s      = 1'b1;
                    flush_idex_s = 1'b1;
                    state_d      = ST_BUBBLE;
                end else if (hilo_wait_s) begin
                    stall_s      = 1'b1;
                    flush_idex_s = 1'b1;
                    state_d      = ST_MDU_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BUBBLE: begin
                // Load has reached MEM; the consumer now forwards from there.
                state_d = ST_RUN;
            end
            ST_MDU_WAIT: begin
                if (cnt_q > ONE_C) begin
                    stall_s      = 1'b1;
                    flush_idex_s = 1'b1;
                    state_d      = ST_MDU_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and MDU counter registers; reset returns to RUN with an idle MDU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= ZERO_C;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_pc   = stall_s;
    assign bus.stall_ifid = stall_s;
    assign bus.flush_ifid = flush_ifid_s;
    assign bus.flush_idex = flush_idex_s;
    assign bus.mdu_busy   = mdu_busy_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for forwarding, load-use and
// branch behaviour, plus hand sequences for MDU stalls and asynchronous reset.
module tb_hazard_ctrl;

    // Output word layout: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_ifid,
    //                      flush_ifid, flush_idex, mdu_busy}
    localparam logic [8:0] O_ZERO  = 9'b00_00_0_0_0_0_0;
    localparam logic [8:0] O_STALL = 9'b00_00_1_1_0_1_0;
    localparam logic [8:0] O_FLUSH = 9'b00_00_0_0_1_1_0;
    localparam logic [8:0] O_FA2   = 9'b10_00_0_0_0_0_0;
    localparam logic [8:0] O_FA1   = 9'b01_00_0_0_0_0_0;
    localparam logic [8:0] O_FB1   = 9'b00_01_0_0_0_0_0;
    localparam logic [8:0] O_FB2   = 9'b00_10_0_0_0_0_0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       ut;
        logic [4:0] ex_rw;
        logic       ex_we;
        logic       ex_mr;
        logic       br;
        logic [4:0] mem_rw;
        logic       mem_we;
        logic [4:0] wb_rw;
        logic       wb_we;
        logic [8:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_stall;
    vec_t vecs[$];

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] outs();
        return {bus.fwd_a, bus.fwd_b, bus.stall_pc, bus.stall_ifid,
                bus.flush_ifid, bus.flush_idex, bus.mdu_busy};
    endfunction

    task automatic chk(input string nm, input logic [8:0] exp);
        logic [8:0] got;
        got = outs();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic tick(input string nm, input logic [8:0] exp);
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_rd_hilo = 1'b0;
        bus.ex_rw = 5'd0;  bus.ex_we = 1'b0; bus.ex_memread = 1'b0;
        bus.ex_br_taken = 1'b0; bus.ex_mdu_start = 1'b0;
        bus.mem_rw = 5'd0; bus.mem_we = 1'b0;
        bus.wb_rw = 5'd0;  bus.wb_we = 1'b0;
    endtask

    task automatic set_in(input vec_t v);
        clear_in();
        bus.id_rs = v.rs;         bus.id_rt = v.rt;
        bus.id_use_rs = v.ur;     bus.id_use_rt = v.ut;
        bus.ex_rw = v.ex_rw;      bus.ex_we = v.ex_we;
        bus.ex_memread = v.ex_mr; bus.ex_br_taken = v.br;
        bus.mem_rw = v.mem_rw;    bus.mem_we = v.mem_we;
        bus.wb_rw = v.wb_rw;      bus.wb_we = v.wb_we;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_stall = 0;

        //            rs     rt     ur    ut    ex_rw  exwe  exmr  br    mem_rw mwe   wb_rw  wwe   exp
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});
        vecs.push_back('{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, O_FA2});
        vecs.push_back('{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, O_FA1});
        vecs.push_back('{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, O_ZERO});
        vecs.push_back('{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, O_FB1});
        vecs.push_back('{5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, O_ZERO});
        vecs.push_back('{5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 9'b10_01_0_0_0_0_0});
        // load-use on rt, then the bubble cycle forwards from MEM
        vecs.push_back('{5'd0, 5'd8, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_STALL});
        vecs.push_back('{5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, O_FB2});
        // loads that must not interlock: r0, no write, operand unused
        vecs.push_back('{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});
        vecs.push_back('{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});
        vecs.push_back('{5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});
        // branch alone, branch beating load-use, then a load-use proves RUN state
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_FLUSH});
        vecs.push_back('{5'd0, 5'd8, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_FLUSH});
        vecs.push_back('{5'd10, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_STALL});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});
        // stall with WB forward visible, then BUBBLE ignores the same load inputs
        vecs.push_back('{5'd10, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 9'b01_00_1_1_0_1_0});
        vecs.push_back('{5'd10, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, O_FA1});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_ZERO});

        // Reset
        rst = 1'b1;
        clear_in();
        @(negedge clk);
        chk("reset_hold", O_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick("reset_release", O_ZERO);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i]);
            tick($sformatf("vec%0d", i), vecs[i].exp);
        end

        // MDU start with mfhi in ID: stalls in cycles 0..3, busy in cycles 1..4
        clear_in();
        bus.ex_mdu_start = 1'b1;
        bus.id_rd_hilo = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic s;
            logic b;
            if (k == 1) bus.ex_mdu_start = 1'b0;
            if (k == 5) bus.id_rd_hilo = 1'b0;
            s = (k < 4);
            b = (k >= 1) && (k <= 4);
            @(negedge clk);
            if (bus.stall_pc) n_stall++;
            chk($sformatf("mdu_wait_c%0d", k), {4'b0000, s, s, 1'b0, s, b});
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_stall != 4) begin
            n_err++;
            $display("FAIL mdu_stall_count: got %0d required %0d", n_stall, 4);
        end

        // Restart while busy reloads the full latency
        clear_in();
        for (int k = 0; k < 8; k++) begin
            bus.ex_mdu_start = (k == 0 || k == 2) ? 1'b1 : 1'b0;
            tick($sformatf("mdu_restart_c%0d", k), {8'b0000_0000, (k >= 1 && k <= 6) ? 1'b1 : 1'b0});
        end

        // Reset asserted mid MDU_WAIT drops stalls and busy without a clock edge
        clear_in();
        bus.ex_mdu_start = 1'b1;
        bus.id_rd_hilo = 1'b1;
        tick("rst_wait_c0", 9'b00_00_1_1_0_1_0);
        bus.ex_mdu_start = 1'b0;
        @(negedge clk);
        chk("rst_wait_c1", 9'b00_00_1_1_0_1_1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", O_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick("rst_after", O_ZERO);
        bus.id_rd_hilo = 1'b0;
        tick("rst_idle", O_ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
